// File: rtl/seq_u_bam_mult.sv
// Iterative unsigned broken-array multiplier: one partial-product row per clock,
// with optional horizontal (H) and vertical (V) cuts selected per operation.
module seq_u_bam_mult #(
   parameter int N = 8,
   parameter int H = 2,
   parameter int V = 11
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   input  logic           approx,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] out,
   output logic           busy
);

   localparam int JW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   a_q, a_d;
   logic [N-1:0]   b_q, b_d;
   logic           approx_q, approx_d;
   logic [2*N-1:0] acc_q, acc_d;
   logic [JW-1:0]  j_q, j_d;

   logic [JW-1:0]  start_s;
   logic [N-1:0]   rowmask_s;
   logic [N-1:0]   bsel_s;
   logic [2*N-1:0] row_s;

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         approx_q <= 1'b0;
         acc_q    <= '0;
         j_q      <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         approx_q <= approx_d;
         acc_q    <= acc_d;
         j_q      <= j_d;
      end
   end

   // Kept bits of the current row: column i survives unless cut by i+j < V.
   always_comb begin
      start_s = approx ? JW'(H) : '0;
      for (int i = 0; i < N; i++) begin
         rowmask_s[i] = !approx_q || ((i + int'(j_q)) >= V);
      end
      bsel_s = b_q >> j_q;
      if (bsel_s[0]) begin
         row_s = {{N{1'b0}}, a_q & rowmask_s} << j_q;
      end else begin
         row_s = '0;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = (start_s == JW'(N)) ? DONE : BUSY;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (j_q == JW'(N - 1)) begin
               state_d = DONE;
            end else begin
               state_d = BUSY;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand capture and row accumulation; rows with an empty mask still cost a cycle.
   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      approx_d = approx_q;
      acc_d    = acc_q;
      j_d      = j_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d      = a;
               b_d      = b;
               approx_d = approx;
               acc_d    = '0;
               j_d      = start_s;
            end else begin
               j_d      = j_q;
            end
         end
         BUSY: begin
            acc_d = acc_q + row_s;
            j_d   = j_q + JW'(1);
         end
         DONE: begin
            acc_d = acc_q;
         end
         default: begin
            acc_d = '0;
            j_d   = '0;
         end
      endcase
   end

   // Outputs decoded from state only.
   always_comb begin
      in_ready  = (state_q == IDLE);
      busy      = (state_q == BUSY);
      out_valid = (state_q == DONE);
      out       = acc_q;
   end

endmodule

// File: tb/tb_seq_u_bam_mult.sv
// Bench for seq_u_bam_mult: four parameter variants checked every cycle against a
// bit-summing reference model, plus directed literal cases, backpressure and reset.
module tb_seq_u_bam_mult;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic iv[4], ir[4], ov[4], ordy[4], bz[4], ap[4];
   logic [7:0] a_s[4], b_s[4];
   logic [15:0] o0, o1;
   logic [11:0] o2;
   logic [7:0]  o3;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit pend[4];
   int rdy[4];
   logic [15:0] expv[4];

   seq_u_bam_mult #(.N(8), .H(2), .V(11)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
      .a(a_s[0]), .b(b_s[0]), .approx(ap[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out(o0), .busy(bz[0]));
   seq_u_bam_mult #(.N(8), .H(0), .V(0)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
      .a(a_s[1]), .b(b_s[1]), .approx(ap[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out(o1), .busy(bz[1]));
   seq_u_bam_mult #(.N(6), .H(1), .V(5)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
      .a(a_s[2][5:0]), .b(b_s[2][5:0]), .approx(ap[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out(o2), .busy(bz[2]));
   seq_u_bam_mult #(.N(4), .H(4), .V(0)) u3 (.clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
      .a(a_s[3][3:0]), .b(b_s[3][3:0]), .approx(ap[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .out(o3), .busy(bz[3]));

   function automatic int pn(input int k);
      case (k) 0: return 8; 1: return 8; 2: return 6; default: return 4; endcase
   endfunction
   function automatic int ph(input int k);
      case (k) 0: return 2; 1: return 0; 2: return 1; default: return 4; endcase
   endfunction
   function automatic int pv(input int k);
      case (k) 0: return 11; 1: return 0; 2: return 5; default: return 0; endcase
   endfunction

   // Reference: sum every kept partial-product bit at weight 2^(i+j).
   function automatic logic [15:0] ref_mul(input int k, input logic [7:0] a, input logic [7:0] b, input logic x);
      longint s = 0;
      for (int j = 0; j < pn(k); j++)
         for (int i = 0; i < pn(k); i++)
            if (a[i] && b[j] && (!x || (j >= ph(k) && i + j >= pv(k))))
               s += longint'(1) << (i + j);
      return s[15:0];
   endfunction

   function automatic int lat(input int k, input logic x);
      return pn(k) - (x ? ph(k) : 0);
   endfunction

   function automatic logic [15:0] get_out(input int k);
      case (k)
         0: return o0;
         1: return o1;
         2: return {4'b0, o2};
         default: return {8'b0, o3};
      endcase
   endfunction

   task automatic chk(input bit ok, input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s inst=%0d actual=%h expected=%h cyc=%0d", nm, k, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Cycle-by-cycle comparison against the model; the model then advances on handshakes.
   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (!rst_n) begin
            pend[k] = 1'b0;
         end else begin
            bit ev;
            ev = pend[k] && (cyc >= rdy[k]);
            chk(ov[k] == ev, "out_valid", k, 16'(ov[k]), 16'(ev));
            chk(ir[k] == !pend[k], "in_ready", k, 16'(ir[k]), 16'(!pend[k]));
            chk(bz[k] == (pend[k] && !ev), "busy", k, 16'(bz[k]), 16'(pend[k] && !ev));
            if (ev) chk(get_out(k) == expv[k], "out", k, get_out(k), expv[k]);
            if (ev && ordy[k]) begin
               pend[k] = 1'b0;
            end else if (!pend[k] && iv[k]) begin
               pend[k] = 1'b1;
               expv[k] = ref_mul(k, a_s[k], b_s[k], ap[k]);
               rdy[k]  = cyc + 1 + lat(k, ap[k]);
            end
         end
      end
   end

   task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b, input logic x,
                         input logic [15:0] exp, input int exp_lat);
      int n;
      n = 0;
      while (!ir[k] && n < 50) begin @(posedge clk); #1; n++; end
      chk(ir[k] == 1'b1, "ready_wait", k, 16'(ir[k]), 16'd1);
      a_s[k] = a; b_s[k] = b; ap[k] = x; iv[k] = 1'b1;
      @(posedge clk); #1;
      iv[k] = 1'b0;
      n = 0;
      while (!ov[k] && n < 64) begin @(posedge clk); #1; n++; end
      chk(ov[k] == 1'b1, "valid_seen", k, 16'(ov[k]), 16'd1);
      chk(n == exp_lat, "latency", k, 16'(n), 16'(exp_lat));
      chk(get_out(k) == exp, "directed_out", k, get_out(k), exp);
   endtask

   task automatic finish_op(input int k);
      @(posedge clk); #1;
      chk(ov[k] == 1'b0, "valid_drop", k, 16'(ov[k]), 16'd0);
      chk(ir[k] == 1'b1, "back_idle", k, 16'(ir[k]), 16'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
         iv[k] = 1'b0; ordy[k] = 1'b1; ap[k] = 1'b0; a_s[k] = 8'h00; b_s[k] = 8'h00;
      end
      #1;
      for (int k = 0; k < 4; k++) begin
         chk(ov[k] == 1'b0, "rst_valid", k, 16'(ov[k]), 16'd0);
         chk(bz[k] == 1'b0, "rst_busy", k, 16'(bz[k]), 16'd0);
         chk(ir[k] == 1'b1, "rst_ready", k, 16'(ir[k]), 16'd1);
         chk(get_out(k) == 16'h0000, "rst_out", k, get_out(k), 16'h0000);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      chk(ref_mul(0, 8'hFF, 8'hFF, 1'b1) == 16'hD000, "model_pin_ff", 0, ref_mul(0, 8'hFF, 8'hFF, 1'b1), 16'hD000);
      chk(ref_mul(0, 8'h0F, 8'hFF, 1'b0) == 16'h0EF1, "model_pin_0f", 0, ref_mul(0, 8'h0F, 8'hFF, 1'b0), 16'h0EF1);
      chk(ref_mul(3, 8'h0F, 8'h0F, 1'b0) == 16'h00E1, "model_pin_n4", 3, ref_mul(3, 8'h0F, 8'h0F, 1'b0), 16'h00E1);

      run_op(0, 8'hFF, 8'hFF, 1'b1, 16'hD000, 6); finish_op(0);
      run_op(0, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 8); finish_op(0);
      run_op(0, 8'h80, 8'h10, 1'b1, 16'h0800, 6); finish_op(0);
      run_op(0, 8'h0F, 8'hFF, 1'b1, 16'h0000, 6); finish_op(0);
      run_op(0, 8'h0F, 8'hFF, 1'b0, 16'h0EF1, 8); finish_op(0);
      run_op(3, 8'h0F, 8'h0F, 1'b1, 16'h0000, 0); finish_op(3);
      run_op(3, 8'h0F, 8'h0F, 1'b0, 16'h00E1, 4); finish_op(3);

      // Backpressure: held result must survive new operand pulses.
      ordy[0] = 1'b0;
      run_op(0, 8'hFF, 8'hFF, 1'b1, 16'hD000, 6);
      repeat (5) begin
         a_s[0] = 8'($urandom); b_s[0] = 8'($urandom); ap[0] = 1'($urandom); iv[0] = 1'b1;
         @(posedge clk); #1;
         chk(o0 == 16'hD000, "bp_out", 0, o0, 16'hD000);
         chk(ir[0] == 1'b0, "bp_ready", 0, 16'(ir[0]), 16'd0);
         chk(ov[0] == 1'b1, "bp_valid", 0, 16'(ov[0]), 16'd1);
      end
      iv[0] = 1'b0; ordy[0] = 1'b1;
      finish_op(0);

      // Asynchronous reset three edges into an exact operation.
      a_s[0] = 8'hFF; b_s[0] = 8'hFF; ap[0] = 1'b0; iv[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk(o0 == 16'h0000, "arst_out", 0, o0, 16'h0000);
      chk(ov[0] == 1'b0, "arst_valid", 0, 16'(ov[0]), 16'd0);
      chk(bz[0] == 1'b0, "arst_busy", 0, 16'(bz[0]), 16'd0);
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_op(0, 8'h80, 8'h10, 1'b1, 16'h0800, 6); finish_op(0);

      // Randomized regression with input gaps and output stalls.
      for (int k = 0; k < 3; k++) begin
         for (int op = 0; op < 1000; op++) begin
            int t;
            bit done;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            a_s[k] = 8'($urandom); b_s[k] = 8'($urandom); ap[k] = 1'($urandom); iv[k] = 1'b1;
            @(posedge clk); #1;
            iv[k] = 1'b0;
            t = 0;
            done = 1'b0;
            while (!done && t < 200) begin
               ordy[k] = 1'($urandom_range(0, 1));
               @(negedge clk);
               done = ov[k] && ordy[k];
               @(posedge clk); #1;
               t++;
            end
            if (!done) chk(1'b0, "rand_timeout", k, 16'(t), 16'd200);
         end
         ordy[k] = 1'b1;
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
